fetch_decode_sequencer: RTL and testbench

- Control sequencer that sits directly upstream of the program counter in the nic8 CPU.
- Fetches the opcode byte at the current pc from program ROM, latches it into an instruction register, and decodes it.
- Generates the pc control strobes `do_jump` and `immediate`, plus the data-bus source select and destination load enables for the datapath.
- Two-state fetch/execute machine with a terminal HALT state.

---
 rtl/fetch_decode_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_decode_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_sequencer.sv
// rtl/fetch_decode_sequencer.sv - nic8 fetch/decode sequencer driving pc strobes, bus source and load enables
// Two-state fetch/execute machine with terminal HALT; strobes are combinational from state, ir and flags.
module fetch_decode_sequencer #(
  parameter logic [7:0] HALT_OP = 8'hFF,
  parameter int         NUM_DST = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rom_data,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic               do_jump,
  output logic               immediate,
  output logic [2:0]         bus_src,
  output logic [NUM_DST-1:0] load_en,
  output logic [7:0]         ir,
  output logic               fetching,
  output logic               halted
);

  localparam logic [2:0] SRC_ROM = 3'd5;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_DST-1:0] dst_onehot;
  logic               taken;
  logic [2:0]         mov_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ir    <= 8'h00;
    end else begin
      state <= state_next;
      if (state == FETCH) ir <= rom_data;
    end
  end

  // dst codes beyond the destination count decode to no load
  always_comb begin
    dst_onehot = '0;
    for (int i = 0; i < NUM_DST; i++) begin
      if (ir[2:0] == 3'(i)) dst_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (ir[1:0])
      2'b00:   taken = 1'b1;
      2'b01:   taken = flag_z;
      2'b10:   taken = flag_c;
      default: taken = ~flag_z;
    endcase
  end

  assign mov_src = (ir[5:3] > 3'd4) ? 3'd0 : ir[5:3];

  always_comb begin
    state_next = state;
    do_jump    = 1'b0;
    immediate  = 1'b0;
    bus_src    = 3'd0;
    load_en    = '0;
    case (state)
      FETCH: begin
        immediate  = 1'b1;
        bus_src    = SRC_ROM;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (ir[7:6])
          2'b00: begin
            bus_src = mov_src;
            load_en = dst_onehot;
          end
          2'b01: begin
            bus_src   = SRC_ROM;
            load_en   = dst_onehot;
            immediate = 1'b1;
          end
          2'b10: begin
            // not-taken jumps still have to step over the target byte
            if (taken) begin
              bus_src = SRC_ROM;
              do_jump = 1'b1;
            end else begin
              immediate = 1'b1;
            end
          end
          default: begin
            if (ir == HALT_OP) state_next = HALT;
          end
        endcase
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign fetching = (state == FETCH);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// tb/tb_fetch_decode_sequencer.sv - randomized self-checking bench for fetch_decode_sequencer
// Expected strobes come from an instruction-level model of the decode rules.
module tb_fetch_decode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_data = 8'h00;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;
  logic       do_jump, immediate, fetching, halted;
  logic [2:0] bus_src;
  logic [4:0] load_en;
  logic [7:0] ir;

  int checks = 0;
  int errors = 0;

  fetch_decode_sequencer #(.HALT_OP(8'hFF), .NUM_DST(5)) dut (
    .clk(clk), .reset(reset), .rom_data(rom_data), .flag_z(flag_z), .flag_c(flag_c),
    .do_jump(do_jump), .immediate(immediate), .bus_src(bus_src), .load_en(load_en),
    .ir(ir), .fetching(fetching), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dj;
    logic       imm;
    logic       src_known;
    logic [2:0] src;
    logic [4:0] ld;
    logic       halt_next;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic z, input logic c);
    exp_t e;
    int cls, src, dst, cond;
    bit take;
    cls  = op / 64;
    src  = (op / 8) % 8;
    dst  = op % 8;
    cond = op % 4;
    e = '0;
    case (cls)
      0: begin
        e.src_known = 1'b1;
        e.src = (src > 4) ? 3'd0 : 3'(src);
        e.ld  = (dst < 5) ? 5'(1 << dst) : 5'd0;
      end
      1: begin
        e.src_known = 1'b1;
        e.src = 3'd5;
        e.imm = 1'b1;
        e.ld  = (dst < 5) ? 5'(1 << dst) : 5'd0;
      end
      2: begin
        take = (cond == 0) || (cond == 1 && z) || (cond == 2 && c) || (cond == 3 && !z);
        if (take) begin
          e.dj = 1'b1;
          e.src_known = 1'b1;
          e.src = 3'd5;
        end else begin
          e.imm = 1'b1;
        end
      end
      default: e.halt_next = (op == 8'hFF);
    endcase
    return e;
  endfunction

  task automatic invariants();
    chk("inv_jump_imm", 32'(do_jump & immediate), 0);
    chk("inv_onehot", 32'($countones(load_en) <= 1), 1);
  endtask

  // Entered at a negedge in a FETCH cycle; leaves at the negedge of the following cycle.
  task automatic exec_instr(input logic [7:0] op, input logic [7:0] operand,
                            input logic z, input logic c);
    exp_t e;
    rom_data = op;
    flag_z = 1'($urandom);
    flag_c = 1'($urandom);
    #1;
    chk("f_fetching", 32'(fetching), 1);
    chk("f_imm", 32'(immediate), 1);
    chk("f_jump", 32'(do_jump), 0);
    chk("f_bus", 32'(bus_src), 5);
    chk("f_load", 32'(load_en), 0);
    chk("f_halted", 32'(halted), 0);
    @(negedge clk);
    rom_data = operand;
    flag_z = z;
    flag_c = c;
    #1;
    e = model(op, z, c);
    chk("x_ir", 32'(ir), 32'(op));
    chk("x_fetching", 32'(fetching), 0);
    chk("x_halted", 32'(halted), 0);
    chk("x_jump", 32'(do_jump), 32'(e.dj));
    chk("x_imm", 32'(immediate), 32'(e.imm));
    chk("x_load", 32'(load_en), 32'(e.ld));
    if (e.src_known) chk("x_bus", 32'(bus_src), 32'(e.src));
    invariants();
    @(negedge clk);
  endtask

  // Entered at a negedge; leaves at the negedge of the first post-reset FETCH cycle.
  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("r_fetching", 32'(fetching), 1);
    chk("r_ir", 32'(ir), 0);
    chk("r_halted", 32'(halted), 0);
    chk("r_load", 32'(load_en), 0);
    chk("r_jump", 32'(do_jump), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    @(negedge clk);
    apply_reset();

    exec_instr(8'h41, 8'h2A, 1'b0, 1'b0);
    exec_instr(8'h03, 8'h00, 1'b0, 1'b0);
    exec_instr(8'h81, 8'h10, 1'b1, 1'b0);
    exec_instr(8'h81, 8'h10, 1'b0, 1'b0);
    exec_instr(8'h80, 8'h20, 1'b1, 1'b0);
    exec_instr(8'h83, 8'h30, 1'b1, 1'b0);
    exec_instr(8'h82, 8'h30, 1'b0, 1'b1);
    exec_instr(8'h82, 8'h30, 1'b1, 1'b0);
    exec_instr(8'h3F, 8'h00, 1'b0, 1'b0);
    exec_instr(8'h47, 8'h00, 1'b0, 1'b0);
    exec_instr(8'hC5, 8'h00, 1'b0, 1'b0);

    exec_instr(8'hFF, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      rom_data = 8'($urandom);
      flag_z = 1'($urandom);
      flag_c = 1'($urandom);
      #1;
      chk("h_halted", 32'(halted), 1);
      chk("h_fetching", 32'(fetching), 0);
      chk("h_strobes", {do_jump, immediate, load_en}, 0);
      @(negedge clk);
    end
    apply_reset();
    chk("r_imm", 32'(immediate), 1);

    // reset landing in the EXEC cycle of an LDI
    rom_data = 8'h41;
    #1;
    @(negedge clk);
    rom_data = 8'h2A;
    #1;
    chk("x_ldi_load", 32'(load_en), 5'b00010);
    apply_reset();
    chk("r_imm", 32'(immediate), 1);
    chk("r_bus", 32'(bus_src), 5);

    for (int n = 0; n < 200; n++) begin
      op = 8'($urandom);
      if (op == 8'hFF) op = 8'hC0;
      exec_instr(op, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
